// File: rtl/riscv_mem_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Latency: n/a (types only).  Backpressure: n/a.
package riscv_mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    localparam logic [DW_DEF/8-1:0] BE_ALL = '1;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HOLD = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/riscv_mem_arb_prio.sv
// Picks fetch vs data winner and tracks the data-grant streak that starves fetch.
// Latency: winner is combinational; streak updates on the clock.  Backpressure: none.
module riscv_mem_arb_prio
    import riscv_mem_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   gnt_vld,
    input  owner_e gnt_own,
    output owner_e winner
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    logic [SW-1:0] streak;
    logic          at_max;

    assign at_max = (streak == SW'(MAX_D_STREAK));
    assign winner = (d_req && !(if_req && at_max)) ? OWN_D : OWN_IF;

    // The streak only matters while fetch is waiting, so any idle-fetch cycle resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (!if_req || (gnt_vld && gnt_own == OWN_IF)) begin
            streak <= '0;
        end else if (gnt_vld && gnt_own == OWN_D && !at_max) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one transaction in flight.
// Latency: grant same cycle as mem_ready, response passed through combinationally; watchdog aborts after TIMEOUT.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ready,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int BW = DW / 8;
    localparam int TW = $clog2(TIMEOUT);

    arb_state_e    state;
    owner_e        owner;
    owner_e        cur_own;
    owner_e        winner;
    logic [TW-1:0] timer;

    logic in_idle, in_hold, in_wait;
    logic gnt_fire, rsp_fire, tmo, done;

    riscv_mem_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .if_req  (if_req),
        .d_req   (d_req),
        .gnt_vld (gnt_fire),
        .gnt_own (cur_own),
        .winner  (winner)
    );

    always_comb begin
        in_idle  = (state == ARB_IDLE);
        in_hold  = (state == ARB_HOLD);
        in_wait  = (state == ARB_WAIT);
        // Owner is only chosen in IDLE; once latched it stays locked until the response.
        cur_own  = in_idle ? winner : owner;
        mem_req  = reset && ((in_idle && (if_req || d_req)) || in_hold);
        gnt_fire = mem_req && mem_ready;
        rsp_fire = in_wait && mem_rvalid;
        tmo      = in_wait && !mem_rvalid && (timer == TW'(TIMEOUT - 1));
        done     = rsp_fire || tmo;

        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (mem_req) begin
            if (cur_own == OWN_D) begin
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end else begin
                mem_addr  = if_addr;
                mem_be    = {BW{BE_ALL[0]}};
            end
        end

        if_gnt    = gnt_fire && (cur_own == OWN_IF);
        d_gnt     = gnt_fire && (cur_own == OWN_D);
        if_rvalid = done && (owner == OWN_IF);
        d_rvalid  = done && (owner == OWN_D);
        err       = tmo;
        if_rdata  = (rsp_fire && owner == OWN_IF) ? mem_rdata : '0;
        d_rdata   = (rsp_fire && owner == OWN_D)  ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ARB_IDLE;
            owner <= OWN_IF;
            timer <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (if_req || d_req) begin
                        owner <= winner;
                        timer <= '0;
                        state <= mem_ready ? ARB_WAIT : ARB_HOLD;
                    end
                end
                ARB_HOLD: begin
                    if (mem_ready) begin
                        timer <= '0;
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (done) begin
                        state <= ARB_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter; expected grant/response events are queued and checked by a monitor.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        man_rvalid, auto_rvalid, auto_en;
    logic [31:0] man_rdata, auto_rdata;
    int          auto_n;

    assign mem_rvalid = man_rvalid | auto_rvalid;
    assign mem_rdata  = man_rdata | auto_rdata;

    riscv_mem_arbiter #(
        .AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(64)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        chk_cnt++;
        if (act === exp_v) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // vec = {if_gnt, d_gnt, if_rvalid, d_rvalid, err}
    typedef struct {
        logic [4:0]  vec;
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];

    task automatic push_gnt(input logic is_d, input int c, input logic [31:0] a,
                            input logic we, input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        e.vec = is_d ? 5'b01000 : 5'b10000;
        e.cyc = c; e.addr = a; e.we = we; e.wdata = wd; e.be = be; e.dat = '0;
        sb.push_back(e);
    endtask

    task automatic push_rsp(input logic is_d, input int c, input logic [31:0] dat, input logic e_err);
        exp_t e;
        e.vec = (is_d ? 5'b00010 : 5'b00100) | {4'b0, e_err};
        e.cyc = c; e.addr = '0; e.we = 1'b0; e.wdata = '0; e.be = '0; e.dat = dat;
        sb.push_back(e);
    endtask

    logic [4:0] mon_v;
    exp_t       mon_e;

    always @(negedge clk) begin
        mon_v = {if_gnt, d_gnt, if_rvalid, d_rvalid, err};
        if (mon_v != 5'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_event", 32'(mon_v), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("event_kind", 32'(mon_v), 32'(mon_e.vec));
                chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.vec[4] || mon_e.vec[3]) begin
                    chk("gnt_mem_addr", mem_addr, mon_e.addr);
                    chk("gnt_mem_we", 32'(mem_we), 32'(mon_e.we));
                    chk("gnt_mem_wdata", mem_wdata, mon_e.wdata);
                    chk("gnt_mem_be", 32'(mem_be), 32'(mon_e.be));
                end else begin
                    chk("if_rdata", if_rdata, mon_e.vec[2] ? mon_e.dat : 32'h0);
                    chk("d_rdata", d_rdata, mon_e.vec[1] ? mon_e.dat : 32'h0);
                end
            end
        end
    end

    // Memory that answers exactly one cycle after each accepted request.
    logic auto_pend;
    initial begin
        auto_rvalid = 1'b0;
        auto_rdata  = '0;
        auto_n      = 0;
        forever begin
            @(negedge clk);
            auto_pend = auto_en && mem_req && mem_ready;
            @(posedge clk);
            #1;
            auto_rvalid = auto_pend;
            auto_rdata  = auto_pend ? (32'hCAFE0000 | 32'(auto_n)) : 32'h0;
            if (auto_pend) auto_n++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int c;
    logic [3:0]  st_be   [2];
    logic [31:0] st_addr [2];

    initial begin
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h1; d_be = 4'hF;
        mem_ready = 1'b1; man_rvalid = 1'b0; man_rdata = '0; auto_en = 1'b0;

        // Requests held during reset must produce nothing.
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_gnts", 32'({if_gnt, d_gnt}), 32'h0);
        chk("rst_rvalid_err", 32'({if_rvalid, d_rvalid, err}), 32'h0);
        step; step;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        step;
        reset = 1'b1;

        // 1: single load
        step; c = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_be = 4'hF;
        push_gnt(1'b1, c, 32'h4, 1'b0, 32'h0, 4'hF);
        push_rsp(1'b1, c + 1, 32'h12345678, 1'b0);
        step;
        d_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h12345678;
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        step;

        // 2: both requesters saturated, starvation guard every 5th grant
        step; c = cyc;
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_addr = 32'h200; d_we = 1'b0;
        auto_n = 0; auto_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                push_gnt(1'b0, c + 2 * i, 32'h100, 1'b0, 32'h0, 4'hF);
                push_rsp(1'b0, c + 2 * i + 1, 32'hCAFE0000 | 32'(i), 1'b0);
            end else begin
                push_gnt(1'b1, c + 2 * i, 32'h200, 1'b0, 32'h0, 4'hF);
                push_rsp(1'b1, c + 2 * i + 1, 32'hCAFE0000 | 32'(i), 1'b0);
            end
        end
        repeat (20) step;
        if_req = 1'b0; d_req = 1'b0; auto_en = 1'b0;
        step;

        // 3: data held off by mem_ready, fetch arrives mid-hold and goes next
        step; c = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
        if_addr = 32'h104; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) if_req = 1'b1;
            @(negedge clk);
            chk("hold_mem_req", 32'(mem_req), 32'h1);
            chk("hold_mem_addr", mem_addr, 32'h300);
            step;
        end
        mem_ready = 1'b1;
        push_gnt(1'b1, c + 3, 32'h300, 1'b0, 32'h0, 4'hF);
        step;
        d_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h33333333;
        push_rsp(1'b1, c + 4, 32'h33333333, 1'b0);
        push_gnt(1'b0, c + 5, 32'h104, 1'b0, 32'h0, 4'hF);
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        step;
        if_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h44444444;
        push_rsp(1'b0, c + 6, 32'h44444444, 1'b0);
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        step;

        // 4: stores, full and partial byte enables
        st_be[0] = 4'hF; st_addr[0] = 32'h8;
        st_be[1] = 4'h3; st_addr[1] = 32'h18;
        for (int i = 0; i < 2; i++) begin
            step; c = cyc;
            d_req = 1'b1; d_we = 1'b1; d_addr = st_addr[i]; d_wdata = 32'hDEADBEEF; d_be = st_be[i];
            push_gnt(1'b1, c, st_addr[i], 1'b1, 32'hDEADBEEF, st_be[i]);
            push_rsp(1'b1, c + 1, 32'h0, 1'b0);
            step;
            d_req = 1'b0; d_we = 1'b0; d_wdata = '0; d_be = 4'hF; man_rvalid = 1'b1;
            step;
            man_rvalid = 1'b0;
        end

        // 5: fetch never answered -> watchdog abort, late response ignored
        step; c = cyc;
        if_req = 1'b1; if_addr = 32'h40;
        push_gnt(1'b0, c, 32'h40, 1'b0, 32'h0, 4'hF);
        push_rsp(1'b0, c + 64, 32'h0, 1'b1);
        step;
        if_req = 1'b0;
        repeat (64) step;
        man_rvalid = 1'b1; man_rdata = 32'h55;
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC;
        push_gnt(1'b1, c + 66, 32'hC, 1'b0, 32'h0, 4'hF);
        step;
        d_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h66;
        push_rsp(1'b1, c + 67, 32'h66, 1'b0);
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        step;

        // 6: reset while waiting for a response
        step; c = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        push_gnt(1'b1, c, 32'h10, 1'b0, 32'h0, 4'hF);
        step;
        d_req = 1'b0;
        #1;
        reset = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h99;
        #1;
        chk("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
        chk("midrst_d_rdata", d_rdata, 32'h0);
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_err", 32'(err), 32'h0);
        step;
        step;
        reset = 1'b1;
        step;
        man_rvalid = 1'b0; man_rdata = '0;
        d_req = 1'b1; d_addr = 32'h14;
        push_gnt(1'b1, cyc, 32'h14, 1'b0, 32'h0, 4'hF);
        step;
        d_req = 1'b0; man_rvalid = 1'b1; man_rdata = 32'h77;
        push_rsp(1'b1, cyc, 32'h77, 1'b0);
        step;
        man_rvalid = 1'b0; man_rdata = '0;

        repeat (5) step;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
